// File: rtl/mux_pkg.sv
// Shared constants for the arbitrating output multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_NUM_IN = 3;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester after ptr, wrapping at NUM_IN-1.
module rr_pick #(
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate back to ptr+1 so the closest requester wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_IN);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 multiplexer with fixed or round-robin selection and a single
// registered output stage that refills in the same cycle it drains.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int NUM_IN = DEFAULT_NUM_IN,
  localparam int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic             load_en;
  logic             xfer;
  logic             grant_ok;
  logic             pick_valid;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] words [NUM_IN];

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Fixed mode offers ready to sel regardless of valid; round-robin only to a requester.
  always_comb begin
    load_en  = !out_valid || out_ready;
    grant    = (mode == MODE_RR) ? rr_grant : sel;
    grant_ok = (mode == MODE_RR) ? pick_valid : (int'(sel) < NUM_IN);
    in_ready = '0;
    if (grant_ok && load_en && !rst) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= words[grant];
      out_sel   <= grant;
      ptr       <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_arb_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;

  int vectors     = 0;
  int miscompares = 0;

  int m_ptr   = NUM_IN - 1;
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_sel   = 0;

  arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  // Expected ready vector from the handshake rules and the model's output/pointer state.
  function automatic logic [NUM_IN-1:0] exp_ready();
    logic [NUM_IN-1:0] r = '0;
    bit le = !m_valid || out_ready;
    if (rst || !le) return '0;
    if (mode == 1'b0) begin
      if (int'(sel) < NUM_IN) r[sel] = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        int c = (m_ptr + k) % NUM_IN;
        if (in_valid[c]) begin
          r[c] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Advance the model across one rising edge, leaving time 1 unit after it.
  task automatic clock_model();
    logic [NUM_IN-1:0] r = exp_ready();
    int g = -1;
    int word = 0;
    bit r_rst = rst;
    bit r_ordy = out_ready;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r[i] && in_valid[i]) begin
        g = i;
        word = int'(in_data[i*WIDTH +: WIDTH]);
      end
    end
    @(posedge clk);
    if (r_rst) begin
      m_valid = 1'b0; m_data = 0; m_sel = 0; m_ptr = NUM_IN - 1;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_data = word; m_sel = g; m_ptr = g;
    end else if (r_ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 3'b111;
    in_data = {8'd3, 8'd2, 8'd1}; out_ready = 1'b1;
    clock_model();
    @(negedge clk);
    vectors++;
    if (in_ready !== 3'b000) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b want %b", in_ready, 3'b000);
    end
    vectors++;
    if ({out_valid, out_data, out_sel} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_out: got v=%b d=%0d s=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
    clock_model();
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    int es[5] = '{0, 1, 2, 0, 1};
    int ed[5] = '{1, 2, 3, 1, 2};
    mode = 1'b1; in_valid = 3'b111; in_data = {8'd3, 8'd2, 8'd1}; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 3'b001) begin
      miscompares++; $display("[TB] FAIL rr_all_ready: got %b want %b", in_ready, 3'b001);
    end
    for (int i = 0; i < 5; i++) begin
      clock_model();
      vectors++;
      if (out_sel !== SEL_W'(es[i]) || out_data !== WIDTH'(ed[i]) || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rr_all_%0d: got s=%0d d=%0d v=%b want s=%0d d=%0d v=1",
                 i, out_sel, out_data, out_valid, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_rr_single();
    int es[5] = '{1, 1, 1, 2, 0};
    in_data = {8'd30, 8'd20, 8'd10};
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3) ? 3'b010 : 3'b101;
      clock_model();
      vectors++;
      if (out_sel !== SEL_W'(es[i]) || out_data !== WIDTH'(10 * (es[i] + 1))) begin
        miscompares++;
        $display("[TB] FAIL rr_single_%0d: got s=%0d d=%0d want s=%0d d=%0d",
                 i, out_sel, out_data, es[i], 10 * (es[i] + 1));
      end
    end
  endtask

  task automatic test_fixed_sel2();
    mode = 1'b0; sel = 2'd2; in_valid = 3'b100; in_data = {8'd6, 8'd0, 8'd0}; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 3'b100) begin
      miscompares++; $display("[TB] FAIL fixed_ready: got %b want %b", in_ready, 3'b100);
    end
    clock_model();
    vectors++;
    if (out_data !== 8'd6 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fixed_out: got d=%0d s=%0d v=%b want 6/2/1", out_data, out_sel, out_valid);
    end
  endtask

  task automatic test_backpressure();
    sel = 2'd0; in_valid = 3'b001; in_data = {8'd0, 8'd0, 8'd1}; out_ready = 1'b1;
    clock_model();
    out_ready = 1'b0; in_data = {8'd0, 8'd0, 8'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 3'b000 || out_data !== 8'd1 || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_%0d: got r=%b d=%0d v=%b want 000/1/1", i, in_ready, out_data, out_valid);
      end
      clock_model();
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 3'b001) begin
      miscompares++; $display("[TB] FAIL unstall_ready: got %b want %b", in_ready, 3'b001);
    end
    clock_model();
    vectors++;
    if (out_data !== 8'd2 || out_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL unstall_out: got d=%0d v=%b want 2/1", out_data, out_valid);
    end
  endtask

  task automatic test_sel_oob();
    sel = 2'd3; in_valid = 3'b111; in_data = {8'd9, 8'd8, 8'd7}; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 3'b000) begin
        miscompares++; $display("[TB] FAIL oob_ready_%0d: got %b want %b", i, in_ready, 3'b000);
      end
      clock_model();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'd2 || out_sel !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL oob_out_%0d: got v=%b d=%0d s=%0d want 0/2/0", i, out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_reset_midhandshake();
    mode = 1'b0; sel = 2'd1; in_valid = 3'b010; in_data = {8'h00, 8'h5A, 8'h00}; out_ready = 1'b1;
    clock_model();
    out_ready = 1'b0; in_valid = 3'b000;
    clock_model();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      miscompares++; $display("[TB] FAIL held_word: got v=%b d=%h want 1/5a", out_valid, out_data);
    end
    rst = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 3'b000) begin
      miscompares++; $display("[TB] FAIL rst_ready: got %b want %b", in_ready, 3'b000);
    end
    clock_model();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sel !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_clear: got v=%b d=%0d s=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
    rst = 1'b0; mode = 1'b1; in_data = {8'd3, 8'd2, 8'd1};
    clock_model();
    vectors++;
    if (out_sel !== 2'd0 || out_data !== 8'd1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_first_rr: got s=%0d d=%0d v=%b want 0/1/1", out_sel, out_data, out_valid);
    end
  endtask

  task automatic test_random();
    logic [NUM_IN-1:0] er;
    rst = 1'b1;
    clock_model();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SEL_W'($urandom_range(0, 3));
      in_valid  = NUM_IN'($urandom);
      in_data   = (NUM_IN*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      er = exp_ready();
      vectors++;
      if (in_ready !== er) begin
        miscompares++; $display("[TB] FAIL rand_ready_%0d: got %b want %b", i, in_ready, er);
      end
      clock_model();
      vectors++;
      if (out_valid !== m_valid || out_data !== WIDTH'(m_data) || out_sel !== SEL_W'(m_sel)) begin
        miscompares++;
        $display("[TB] FAIL rand_out_%0d: got v=%b d=%0d s=%0d want v=%b d=%0d s=%0d",
                 i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_rr_single();
    test_fixed_sel2();
    test_backpressure();
    test_sel_oob();
    test_reset_midhandshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
